// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package reg_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } arb_state_t;

  localparam int NUM_REGS  = 8;
  localparam int REG_SEL_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [N-1:0]         winner,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;

  logic [IW1-1:0] sum_s;
  logic [IW-1:0]  cand_s;

  // Walk candidates ptr, ptr+1, ... modulo N and keep the first eligible one.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    sum_s  = '0;
    cand_s = '0;
    for (int k = 0; k < N; k++) begin
      sum_s  = {1'b0, ptr} + IW1'(k);
      cand_s = (sum_s >= IW1'(N)) ? IW'(sum_s - IW1'(N)) : sum_s[IW-1:0];
      if (!valid && eligible[cand_s]) begin
        valid          = 1'b1;
        winner[cand_s] = 1'b1;
        idx            = cand_s;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Owns the single write port of the 8x16 register file: a post-reset/on-demand
// clear sequence followed by round-robin arbitration between writeback sources.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int                NUM_REQ    = 3,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           clear,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [REG_SEL_W*NUM_REQ-1:0]   req_dr,
  input  logic [DATA_W*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           busy,
  output logic                           LD_REG,
  output logic [REG_SEL_W-1:0]           DR,
  output logic [DATA_W-1:0]              DATA
);

  localparam int                   PTR_W    = $clog2(NUM_REQ);
  localparam logic [REG_SEL_W-1:0] LAST_REG = REG_SEL_W'(NUM_REGS - 1);

  arb_state_t           state_q, state_d;
  logic [REG_SEL_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 ld_reg_q, ld_reg_d;
  logic [REG_SEL_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0]    data_q, data_d;

  logic [NUM_REQ-1:0]   eligible_s;
  logic                 win_valid_s;
  logic [NUM_REQ-1:0]   win_onehot_s;
  logic [PTR_W-1:0]     win_idx_s;

  // A requester granted last cycle may still hold req; mask it so it is not regranted.
  assign eligible_s = req & ~gnt_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .eligible (eligible_s),
    .ptr      (rr_ptr_q),
    .valid    (win_valid_s),
    .winner   (win_onehot_s),
    .idx      (win_idx_s)
  );

  // Next-state and next-output logic for the clear sequencer and arbiter.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    ld_reg_d  = 1'b0;
    dr_d      = dr_q;
    data_d    = data_q;
    case (state_q)
      CLEAR: begin
        ld_reg_d = 1'b1;
        dr_d     = clr_cnt_q;
        data_d   = INIT_VALUE;
        busy_d   = 1'b1;
        if (clr_cnt_q == LAST_REG) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          busy_d    = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + REG_SEL_W'(1);
        end
      end
      IDLE: begin
        busy_d = 1'b0;
        if (clear) begin
          // Clear wins over any request; the request simply stays pending.
          state_d = CLEAR;
          busy_d  = 1'b1;
        end else if (win_valid_s) begin
          gnt_d    = win_onehot_s;
          ld_reg_d = 1'b1;
          dr_d     = req_dr[win_idx_s*REG_SEL_W +: REG_SEL_W];
          data_d   = req_data[win_idx_s*DATA_W +: DATA_W];
          rr_ptr_d = (win_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_s + PTR_W'(1);
        end else begin
          ld_reg_d = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset restarts the full clear sequence.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b1;
      ld_reg_q  <= 1'b0;
      dr_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      ld_reg_q  <= ld_reg_d;
      dr_q      <= dr_d;
      data_q    <= data_d;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign LD_REG = ld_reg_q;
  assign DR     = dr_q;
  assign DATA   = data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_reg_write_arbiter;

  localparam int          NUM_REQ = 3;
  localparam int          DATA_W  = 16;
  localparam logic [15:0] INIT    = 16'h0000;

  logic                  Clk;
  logic                  Reset;
  logic                  clear;
  logic [NUM_REQ-1:0]    req;
  logic [3*NUM_REQ-1:0]  req_dr;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;
  logic                  LD_REG;
  logic [2:0]            DR;
  logic [DATA_W-1:0]     DATA;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int          m_clear_left;
  int          m_ptr;
  logic [2:0]  m_gnt;
  logic        m_busy;
  logic        m_ld;
  logic [2:0]  m_dr;
  logic [15:0] m_data;

  logic [15:0] rf [8];

  reg_write_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .INIT_VALUE (INIT)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (clear),
    .req      (req),
    .req_dr   (req_dr),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .LD_REG   (LD_REG),
    .DR       (DR),
    .DATA     (DATA)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stand-in register file capturing the write port.
  always @(posedge Clk) begin
    if (LD_REG) rf[DR] <= DATA;
  end

  task automatic model_reset();
    m_clear_left = 8;
    m_ptr        = 0;
    m_gnt        = 3'b000;
    m_busy       = 1'b1;
    m_ld         = 1'b0;
    m_dr         = 3'd0;
    m_data       = 16'h0000;
  endtask

  // Expected outputs after one rising edge, given the inputs seen at that edge.
  task automatic model_step();
    int w;
    int i;
    if (!Reset) begin
      model_reset();
    end else if (m_clear_left > 0) begin
      m_ld   = 1'b1;
      m_dr   = 3'(8 - m_clear_left);
      m_data = INIT;
      m_gnt  = 3'b000;
      m_clear_left = m_clear_left - 1;
      m_busy = (m_clear_left != 0);
    end else if (clear) begin
      m_clear_left = 8;
      m_busy = 1'b1;
      m_ld   = 1'b0;
      m_gnt  = 3'b000;
    end else begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        i = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req[i] && !m_gnt[i]) w = i;
      end
      m_gnt = 3'b000;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_ld     = 1'b1;
        m_dr     = req_dr[w*3 +: 3];
        m_data   = req_data[w*16 +: 16];
        m_ptr    = (w + 1) % NUM_REQ;
      end else begin
        m_ld = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0; clear = 1'b0; req = '0; req_dr = '0; req_data = '0;
    model_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if ({gnt, busy, LD_REG, DR, DATA} !== {3'b000, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_values got gnt=%b busy=%b ld=%b dr=%0d data=%h expected 000 1 0 0 0000",
               gnt, busy, LD_REG, DR, DATA);
    end
    Reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({gnt, busy, LD_REG, DR, DATA} !== {3'b000, (k < 8), 1'b1, 3'(k - 1), INIT}) begin
        failures++;
        $display("FAIL clear_write%0d got gnt=%b busy=%b ld=%b dr=%0d data=%h expected 000 %0d 1 %0d %h",
                 k, gnt, busy, LD_REG, DR, DATA, (k < 8), k - 1, INIT);
      end
    end
    tick();
    checks++;
    if ({busy, LD_REG, gnt} !== {1'b0, 1'b0, 3'b000}) begin
      failures++;
      $display("FAIL post_clear_idle got busy=%b ld=%b gnt=%b expected 0 0 000", busy, LD_REG, gnt);
    end
  endtask

  task automatic test_single_write();
    req = 3'b001; req_dr[2:0] = 3'd3; req_data[15:0] = 16'hABCD;
    tick();
    checks++;
    if ({gnt, LD_REG, DR, DATA} !== {3'b001, 1'b1, 3'd3, 16'hABCD}) begin
      failures++;
      $display("FAIL single_grant got gnt=%b ld=%b dr=%0d data=%h expected 001 1 3 abcd", gnt, LD_REG, DR, DATA);
    end
    req = 3'b000;
    tick();
    checks++;
    if ({gnt, LD_REG, DR, DATA} !== {3'b000, 1'b0, 3'd3, 16'hABCD}) begin
      failures++;
      $display("FAIL single_hold got gnt=%b ld=%b dr=%0d data=%h expected 000 0 3 abcd", gnt, LD_REG, DR, DATA);
    end
    checks++;
    if (rf[3] !== 16'hABCD) begin
      failures++;
      $display("FAIL single_rf3 got %h expected abcd", rf[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] prev;
    prev = gnt;
    req = 3'b111;
    req_dr   = {3'd6, 3'd5, 3'd4};
    req_data = {16'h2222, 16'h1111, 16'h0000};
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if ({gnt, busy, LD_REG, DR, DATA} !== {m_gnt, m_busy, m_ld, m_dr, m_data}) begin
        failures++;
        $display("FAIL rr_cycle%0d got gnt=%b ld=%b dr=%0d data=%h expected gnt=%b ld=%b dr=%0d data=%h",
                 k, gnt, LD_REG, DR, DATA, m_gnt, m_ld, m_dr, m_data);
      end
      checks++;
      if ($countones(gnt) != 1 || gnt === prev) begin
        failures++;
        $display("FAIL rr_fairness%0d got gnt=%b after %b expected a different single grant", k, gnt, prev);
      end
      prev = gnt;
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_single_hold();
    logic [5:0] pattern;
    pattern = '0;
    req = 3'b010; req_dr[5:3] = 3'd2; req_data[31:16] = 16'h5A5A;
    for (int k = 0; k < 6; k++) begin
      tick();
      pattern[5 - k] = gnt[1];
      checks++;
      if (LD_REG !== gnt[1] || gnt[0] !== 1'b0 || gnt[2] !== 1'b0) begin
        failures++;
        $display("FAIL hold_mirror%0d got ld=%b gnt=%b expected ld equal to gnt[1] only", k, LD_REG, gnt);
      end
    end
    checks++;
    if (pattern !== 6'b101010) begin
      failures++;
      $display("FAIL hold_pattern got %b expected 101010", pattern);
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_clear_pending();
    clear = 1'b1;
    req = 3'b100; req_dr[8:6] = 3'd5; req_data[47:32] = 16'h1234;
    tick();
    clear = 1'b0;
    checks++;
    if ({gnt, busy, LD_REG} !== {3'b000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL clear_accept got gnt=%b busy=%b ld=%b expected 000 1 0", gnt, busy, LD_REG);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({gnt, LD_REG, DR, DATA} !== {3'b000, 1'b1, 3'(k), INIT}) begin
        failures++;
        $display("FAIL clear_seq%0d got gnt=%b ld=%b dr=%0d data=%h expected 000 1 %0d %h",
                 k, gnt, LD_REG, DR, DATA, k, INIT);
      end
    end
    tick();
    checks++;
    if ({gnt, busy, LD_REG, DR, DATA} !== {3'b100, 1'b0, 1'b1, 3'd5, 16'h1234}) begin
      failures++;
      $display("FAIL clear_then_grant got gnt=%b busy=%b ld=%b dr=%0d data=%h expected 100 0 1 5 1234",
               gnt, busy, LD_REG, DR, DATA);
    end
    req = 3'b000;
    tick();
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (rf[r] !== ((r == 5) ? 16'h1234 : INIT)) begin
        failures++;
        $display("FAIL clear_rf%0d got %h expected %h", r, rf[r], (r == 5) ? 16'h1234 : INIT);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (4) tick();
    #2 Reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({gnt, busy, LD_REG, DR, DATA} !== {3'b000, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      failures++;
      $display("FAIL async_reset got gnt=%b busy=%b ld=%b dr=%0d data=%h expected 000 1 0 0 0000",
               gnt, busy, LD_REG, DR, DATA);
    end
    tick();
    checks++;
    if ({busy, LD_REG, DR} !== {1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_held got busy=%b ld=%b dr=%0d expected 1 0 0", busy, LD_REG, DR);
    end
    Reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({gnt, busy, LD_REG, DR, DATA} !== {3'b000, (k < 7), 1'b1, 3'(k), INIT}) begin
        failures++;
        $display("FAIL restart_seq%0d got gnt=%b busy=%b ld=%b dr=%0d data=%h expected 000 %0d 1 %0d %h",
                 k, gnt, busy, LD_REG, DR, DATA, (k < 7), k, INIT);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_gnt[i] || (!req[i] && $urandom_range(0, 2) == 0)) begin
          req[i] = m_gnt[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          req_dr[i*3 +: 3]    = 3'($urandom);
          req_data[i*16 +: 16] = 16'($urandom);
        end
      end
      clear = (!clear && $urandom_range(0, 39) == 0);
      tick();
      checks++;
      if ({gnt, busy, LD_REG, DR, DATA} !== {m_gnt, m_busy, m_ld, m_dr, m_data}) begin
        failures++;
        $display("FAIL random_cycle%0d got gnt=%b busy=%b ld=%b dr=%0d data=%h expected gnt=%b busy=%b ld=%b dr=%0d data=%h",
                 c, gnt, busy, LD_REG, DR, DATA, m_gnt, m_busy, m_ld, m_dr, m_data);
      end
    end
    clear = 1'b0;
    req   = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_single_hold();
    test_clear_pending();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
